ps2_frame_rx: RTL and testbench

Front-end PS/2 keyboard receiver. It synchronizes and filters the raw PS2_CLK/PS2_DATA lines and deframes 11-bit device-to-host frames (start, 8 data bits LSB first, odd parity, stop). It folds E0/F0 prefixes into flags and delivers one validated scan code per key event as a single-cycle strobe. It sits directly upstream of the ball/colour key-command logic, which consumes scan_code, is_break and is_extended instead of re-deframing raw bits.

---
 rtl/ps2_frame_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the raw lines, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and strobes one scan code per key event.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TmoW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0]  FiltMax = 4'(FILTER_LEN - 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_s, data_s;
    logic            filt_q;
    logic [3:0]      filt_cnt_q;
    logic            fall, timeout;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]      code_q, code_d;
    logic            brk_q, brk_d, ext_q, ext_d;
    logic            valid_q, valid_d, err_q, err_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge CLK) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= 4'd0;
        end else if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltMax) begin
                filt_q     <= clk_s;
                filt_cnt_q <= 4'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 4'd1;
            end
        end else begin
            filt_cnt_q <= 4'd0;
        end
    end

    assign fall    = filt_q && !clk_s && (filt_cnt_q == FiltMax);
    assign timeout = (state_q != StIdle) && (tmo_q == TmoMax);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        // A timeout takes priority over a coincident edge, which is dropped.
        if (timeout) begin
            state_d    = StIdle;
            tmo_d      = '0;
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            brk_d      = brk_pend_q;
                            ext_d      = ext_pend_q;
                            valid_d    = 1'b1;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= 8'h00;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign scan_code   = code_q;
    assign is_break    = brk_q;
    assign is_extended = ext_q;
    assign code_valid  = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: table-driven frames, randomized frames against a prefix/parity model,
// and hand-written timeout, mid-frame reset and clock-glitch sequences.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

    localparam int unsigned FilterLen = 4;
    localparam int unsigned Timeout   = 200;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, is_break, is_extended, frame_err, busy;

    always #5 CLK = ~CLK;

    ps2_frame_rx #(
        .FILTER_LEN    (FilterLen),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .is_break   (is_break),
        .is_extended(is_extended),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor: pulse counts and longest run of each strobe.
    int cv_cnt = 0, err_cnt = 0, cv_run = 0, err_run = 0, cv_max = 0, err_max = 0;
    int busy_seen = 0;
    always @(negedge CLK) begin
        if (code_valid) begin
            cv_cnt++; cv_run++;
            if (cv_run > cv_max) cv_max = cv_run;
        end else cv_run = 0;
        if (frame_err) begin
            err_cnt++; err_run++;
            if (err_run > err_max) err_max = err_run;
        end else err_run = 0;
        if (busy) busy_seen++;
    end

    initial begin
        repeat (90000) @(posedge CLK);
        $display("FAIL watchdog: simulation did not finish, required finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b);
        PS2_DATA = b;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        PS2_DATA = 1'b1;
        wait_cyc(4);
    endtask

    // Reference model: pending prefixes plus the last delivered event.
    logic       m_ext = 1'b0, m_brk = 1'b0, m_isb = 1'b0, m_ise = 1'b0;
    logic [7:0] m_code = 8'h00;

    // kind: 0 = nothing, 1 = code delivered, 2 = frame error
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                               output int kind);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(par);
        if (stop && (ones % 2 == 1)) begin
            if (d == 8'hE0) begin
                m_ext = 1'b1; kind = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1'b1; kind = 0;
            end else begin
                m_code = d; m_isb = m_brk; m_ise = m_ext;
                m_brk = 1'b0; m_ext = 1'b0; kind = 1;
            end
        end else begin
            m_brk = 1'b0; m_ext = 1'b0; kind = 2;
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic par,
                             input logic stop);
        int cv0, e0, kind;
        cv0 = cv_cnt;
        e0  = err_cnt;
        model_frame(d, par, stop, kind);
        send_frame(d, par, stop);
        check({name, "_valid_pulses"}, cv_cnt - cv0, (kind == 1) ? 1 : 0);
        check({name, "_err_pulses"}, err_cnt - e0, (kind == 2) ? 1 : 0);
        check({name, "_scan_code"}, scan_code, m_code);
        check({name, "_is_break"}, is_break, m_isb);
        check({name, "_is_extended"}, is_extended, m_ise);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        int         exp_kind;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cv0, e0, bs0, kind, lat;
        logic [7:0] d;
        logic par, stop;

        vecs[0] = '{8'h75, 1'b0, 1, 8'h75, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 0, 8'h75, 1'b0, 1'b0};
        vecs[2] = '{8'h75, 1'b0, 1, 8'h75, 1'b1, 1'b0};
        vecs[3] = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[4] = '{8'hE0, 1'b0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[5] = '{8'hF0, 1'b0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[6] = '{8'h75, 1'b0, 1, 8'h75, 1'b1, 1'b1};
        vecs[7] = '{8'h1C, 1'b1, 2, 8'h75, 1'b1, 1'b1};
        vecs[8] = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 1'b0};

        wait_cyc(3);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_code_valid", code_valid, 1'b0);
        check("rst_is_break", is_break, 1'b0);
        check("rst_is_extended", is_extended, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 9; i++) begin
            cv0 = cv_cnt;
            e0  = err_cnt;
            par = (~^vecs[i].d) ^ vecs[i].bad_par;
            model_frame(vecs[i].d, par, 1'b1, kind);
            send_frame(vecs[i].d, par, 1'b1);
            check($sformatf("tbl%0d_valid_pulses", i), cv_cnt - cv0,
                  (vecs[i].exp_kind == 1) ? 1 : 0);
            check($sformatf("tbl%0d_err_pulses", i), err_cnt - e0,
                  (vecs[i].exp_kind == 2) ? 1 : 0);
            check($sformatf("tbl%0d_scan_code", i), scan_code, vecs[i].exp_code);
            check($sformatf("tbl%0d_is_break", i), is_break, vecs[i].exp_brk);
            check($sformatf("tbl%0d_is_extended", i), is_extended, vecs[i].exp_ext);
        end

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 5))
                0:       d = 8'hE0;
                1:       d = 8'hF0;
                default: d = 8'($urandom_range(0, 255));
            endcase
            par  = (~^d) ^ ($urandom_range(0, 5) == 0);
            stop = ($urandom_range(0, 7) != 0);
            run_frame($sformatf("rnd%0d", r), d, par, stop);
        end

        // Timeout: pending E0, then start + 4 data bits and an idle line.
        run_frame("to_pre_e0", 8'hE0, 1'b0, 1'b1);
        cv0 = cv_cnt;
        e0  = err_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        PS2_DATA = 1'b0;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge CLK);
            if (i == 20) PS2_CLK = 1'b1;
            if (i == 100) check("to_busy_mid", busy, 1'b1);
            if (frame_err) begin
                lat = i;
                break;
            end
        end
        PS2_DATA = 1'b1;
        n_checks++;
        if (lat < int'(Timeout) || lat > int'(Timeout + FilterLen + 6)) begin
            n_fail++;
            $display("FAIL to_latency: got %0d cycles, required %0d..%0d", lat, Timeout,
                     Timeout + FilterLen + 6);
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cyc(3);
        check("to_busy_after", busy, 1'b0);
        check("to_err_pulses", err_cnt - e0, 1);
        check("to_valid_pulses", cv_cnt - cv0, 0);
        wait_cyc(20);
        run_frame("to_post_75", 8'h75, 1'b0, 1'b1);

        // Mid-frame reset after start + 5 data bits, with a break prefix pending.
        run_frame("rst_pre_f0", 8'hF0, 1'b1, 1'b1);
        cv0 = cv_cnt;
        e0  = err_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        check("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge CLK);
        check("rst_mid_scan_code", scan_code, 8'h00);
        check("rst_mid_is_break", is_break, 1'b0);
        check("rst_mid_is_extended", is_extended, 1'b0);
        check("rst_mid_code_valid", code_valid, 1'b0);
        check("rst_mid_frame_err", frame_err, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        PS2_DATA = 1'b1;
        m_code = 8'h00; m_isb = 1'b0; m_ise = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        wait_cyc(20);
        check("rst_mid_no_valid", cv_cnt - cv0, 0);
        check("rst_mid_no_err", err_cnt - e0, 0);
        run_frame("rst_post_74", 8'h74, 1'b1, 1'b1);

        // Short PS2_CLK glitches while idle.
        e0  = err_cnt;
        bs0 = busy_seen;
        for (int g = 0; g < 6; g++) begin
            PS2_CLK = 1'b0;
            wait_cyc((g % 2 == 1) ? int'(FilterLen) - 1 : 1);
            PS2_CLK = 1'b1;
            wait_cyc(8);
        end
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_no_busy", busy_seen - bs0, 0);
        run_frame("glitch_post_1c", 8'h1C, 1'b0, 1'b1);

        check("valid_pulse_width", cv_max, 1);
        check("err_pulse_width", err_max, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
